// File: rtl/egress_pkg.sv
// Shared types and constants for the egress drain engine.
// Header layout helper lives here so tx and tests agree.
package egress_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAITV,
    S_LATCH,
    S_HDR0,
    S_HDR1,
    S_PAY,
    S_GAP
  } state_e;

  localparam int HDR_BYTES = 2;
  localparam int MIN_GAP   = 3;

  function automatic logic [7:0] hdr0(
    input logic [11:0] t,
    input logic [3:0]  mask
  );
    return {t[11:8], mask};
  endfunction

endpackage

// File: rtl/egress_tx_ctrl_if.sv
// Queue read side plus serial tx side of one egress port.
// master = drain engine, slave = queue and downstream.
interface egress_tx_ctrl_if;

  logic        ptr_fifo_empty;
  logic        ptr_fifo_rd;
  logic        packet_rd_valid;
  logic [15:0] ptr_fifo_dout;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout;
  logic        tx_rdy;
  logic        tx_sof;
  logic        tx_dv;
  logic [7:0]  tx_data;

  modport master (
    input  ptr_fifo_empty,
    input  packet_rd_valid,
    input  ptr_fifo_dout,
    input  data_fifo_dout,
    input  tx_rdy,
    output ptr_fifo_rd,
    output data_fifo_rd,
    output tx_sof,
    output tx_dv,
    output tx_data
  );

  modport slave (
    output ptr_fifo_empty,
    output packet_rd_valid,
    output ptr_fifo_dout,
    output data_fifo_dout,
    output tx_rdy,
    input  ptr_fifo_rd,
    input  data_fifo_rd,
    input  tx_sof,
    input  tx_dv,
    input  tx_data
  );

endinterface

// File: rtl/egress_tx_ctrl_tx_frame_shift.sv
// Output stage: header byte 1 is parked one cycle so that
// RAM bytes (one cycle late) line up right behind it.
module tx_frame_shift (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  input  logic [7:0] hdr0_i,
  input  logic [7:0] hdr1_i,
  input  logic       pay_i,
  input  logic [7:0] din_i,
  output logic       sof_o,
  output logic       dv_o,
  output logic [7:0] data_o
);

  logic       hdr1_vld_q;
  logic [7:0] hdr1_q;
  logic       sof_q;
  logic       dv_q;
  logic [7:0] data_q;

  // start, header-1 slot and payload strobe never overlap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr1_vld_q <= 1'b0;
      hdr1_q     <= '0;
      sof_q      <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      hdr1_vld_q <= start_i;
      if (start_i) hdr1_q <= hdr1_i;
      sof_q <= start_i;
      dv_q  <= start_i | hdr1_vld_q | pay_i;
      unique case (1'b1)
        start_i:    data_q <= hdr0_i;
        hdr1_vld_q: data_q <= hdr1_q;
        pay_i:      data_q <= din_i;
        default:    data_q <= '0;
      endcase
    end
  end

  assign sof_o  = sof_q;
  assign dv_o   = dv_q;
  assign data_o = data_q;

endmodule

// File: rtl/egress_tx_ctrl.sv
// Drains one descriptor at a time from the port queue and
// reframes the payload with a regenerated 2-byte header.
module egress_tx_ctrl
  import egress_pkg::*;
#(
  parameter logic [3:0] PORT_MASK     = 4'b0001,
  parameter int         IFG           = 4,
  parameter int         VALID_TIMEOUT = 64,
  parameter int         LEN_WIDTH     = 12
) (
  input  logic              clk,
  input  logic              rstn,
  egress_tx_ctrl_if.master  bus,
  output logic              busy,
  output logic              err
);

  localparam int GAP_N = (IFG < MIN_GAP) ? MIN_GAP : IFG;
  localparam int TW    = $clog2(VALID_TIMEOUT + 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(VALID_TIMEOUT - 2);
  localparam logic [LEN_WIDTH-1:0] MAX_N =
    LEN_WIDTH'((1 << LEN_WIDTH) - 1 - HDR_BYTES);
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [3:0]           gap_q, gap_d;
  logic                 data_rd_q, data_rd_d;
  logic                 ptr_rd_q;
  logic                 busy_q;
  logic                 err_q, err_d;

  logic [LEN_WIDTH-1:0] n;
  logic [LEN_WIDTH-1:0] t;
  logic                 ovf;
  logic                 start;
  logic                 pay;
  logic                 unused_hi;

  assign unused_hi = ^bus.ptr_fifo_dout[15:LEN_WIDTH];

  assign n   = bus.ptr_fifo_dout[LEN_WIDTH-1:0];
  assign ovf = n > MAX_N;
  assign t   = ovf ? '1 : n + LEN_WIDTH'(HDR_BYTES);

  // state register and every registered output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      byte_cnt_q <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      data_rd_q  <= 1'b0;
      ptr_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      data_rd_q  <= data_rd_d;
      ptr_rd_q   <= (state_d == S_REQ);
      busy_q     <= (state_d != S_IDLE);
      err_q      <= err_d;
    end
  end

  // next state; the read window runs on its own counter
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    data_rd_d  = 1'b0;
    err_d      = 1'b0;
    start      = 1'b0;
    pay        = 1'b0;
    if (data_rd_q) begin
      rd_cnt_d  = rd_cnt_q - ONE;
      data_rd_d = (rd_cnt_q != ONE);
    end
    unique case (state_q)
      S_IDLE: begin
        if (!bus.ptr_fifo_empty && bus.tx_rdy)
          state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAITV;
        tmo_d   = '0;
      end
      S_WAITV: begin
        if (bus.packet_rd_valid) begin
          state_d = S_LATCH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_GAP;
          err_d   = 1'b1;
          gap_d   = GAP_LAST;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_LATCH: begin
        state_d    = S_HDR0;
        start      = 1'b1;
        err_d      = ovf;
        data_rd_d  = 1'b1;
        rd_cnt_d   = (n == '0) ? ONE : n;
        byte_cnt_d = n;
      end
      S_HDR0: state_d = S_HDR1;
      S_HDR1, S_PAY: begin
        state_d = S_PAY;
        pay     = (byte_cnt_q != '0);
        if (pay) begin
          byte_cnt_d = byte_cnt_q - ONE;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  tx_frame_shift u_shift (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (start),
    .hdr0_i  (hdr0(t[11:0], PORT_MASK)),
    .hdr1_i  (t[7:0]),
    .pay_i   (pay),
    .din_i   (bus.data_fifo_dout),
    .sof_o   (bus.tx_sof),
    .dv_o    (bus.tx_dv),
    .data_o  (bus.tx_data)
  );

  assign bus.ptr_fifo_rd  = ptr_rd_q;
  assign bus.data_fifo_rd = data_rd_q;
  assign busy             = busy_q;
  assign err              = err_q;

endmodule

// File: tb/tb_egress_tx_ctrl.sv
// Scoreboard bench: queue model feeds the DUT, expected frames
// are queued at enqueue time and popped by a negedge monitor.
module tb_egress_tx_ctrl;

  localparam logic [3:0] PM = 4'b0001;
  localparam int IFG = 4;
  localparam int VT  = 64;
  localparam int G   = (IFG < 3) ? 3 : IFG;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy;
  logic err;

  egress_tx_ctrl_if bus();

  egress_tx_ctrl #(
    .PORT_MASK     (PM),
    .IFG           (IFG),
    .VALID_TIMEOUT (VT),
    .LEN_WIDTH     (12)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int base;
    bit hold;
    int dly;
  } desc_t;

  typedef struct {
    bit         sof;
    logic [7:0] b;
    bit         last;
  } exp_t;

  desc_t dq[$];
  exp_t  exq[$];
  int    rdq[$];

  int n_cmp    = 0;
  int n_bad    = 0;
  int err_exp  = 0;
  int err_seen = 0;
  int pops     = 0;
  int cyc      = 0;

  task automatic chk(string nm, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) cyc %0d",
               nm, act, act, req, req, cyc);
    end
  endtask

  task automatic chkmin(string nm, longint act, longint lo);
    n_cmp++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d want >= %0d cyc %0d",
               nm, act, lo, cyc);
    end
  endtask

  task automatic push_desc(int n, int base, bit hold);
    desc_t d;
    logic [11:0] t;
    int nt;
    d.n    = n;
    d.base = base;
    d.hold = hold;
    d.dly  = $urandom_range(0, 4);
    dq.push_back(d);
    if (hold) begin
      err_exp++;
      return;
    end
    if (n > 4093) begin
      nt = 4095;
      err_exp++;
    end else begin
      nt = n + 2;
    end
    t = 12'(nt);
    exq.push_back('{1'b1, {t[11:8], PM}, 1'b0});
    exq.push_back('{1'b0, t[7:0], n == 0});
    for (int k = 0; k < n; k++)
      exq.push_back('{1'b0, 8'(base + k), k == n - 1});
    rdq.push_back(n == 0 ? 1 : n);
  endtask

  assign bus.ptr_fifo_empty = (dq.size() == 0);

  always @(posedge clk) cyc <= cyc + 1;

  // queue model: pop, delayed valid, late dout, 1-cycle RAM
  desc_t cur;
  int    vcnt = -1;
  bit    lat  = 1'b0;
  int    cidx = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dq.delete();
      vcnt = -1;
      lat  = 1'b0;
      cidx = 0;
      cur  = '{0, 0, 1'b0, 0};
      bus.packet_rd_valid <= 1'b0;
      bus.ptr_fifo_dout   <= '0;
      bus.data_fifo_dout  <= '0;
    end else begin
      bus.packet_rd_valid <= 1'b0;
      if (lat) begin
        bus.ptr_fifo_dout <= {4'($urandom), 12'(cur.n)};
        lat = 1'b0;
      end
      if (vcnt == 0) begin
        bus.packet_rd_valid <= 1'b1;
        bus.ptr_fifo_dout   <= 16'($urandom);
        lat  = 1'b1;
        cidx = 0;
        vcnt = -1;
      end else if (vcnt > 0) begin
        vcnt--;
      end
      if (bus.ptr_fifo_rd && dq.size() != 0) begin
        cur  = dq.pop_front();
        vcnt = cur.hold ? -1 : cur.dly;
      end
      if (bus.data_fifo_rd) begin
        bus.data_fifo_dout <= (cidx < cur.n) ?
                              8'(cur.base + cidx) : 8'hEE;
        cidx++;
      end
    end
  end

  // monitor: bytes, contiguity, read runs, pop pulses, gaps
  bit cont  = 1'b0;
  bit seen  = 1'b0;
  bit pprev = 1'b0;
  int low   = 0;
  int run   = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rstn) begin
      cont  = 1'b0;
      seen  = 1'b0;
      pprev = 1'b0;
      low   = 0;
      run   = 0;
    end else begin
      if (cont) chk("frame_hole", bus.tx_dv, 1);
      cont = 1'b0;
      if (bus.tx_dv) begin
        if (bus.tx_sof) begin
          if (seen) chkmin("ifg_low", low, G);
          seen = 1'b1;
        end
        low = 0;
        if (exq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got byte 0x%0h want none cyc %0d",
                   bus.tx_data, cyc);
        end else begin
          e = exq.pop_front();
          chk("tx_byte", {bus.tx_sof, bus.tx_data}, {e.sof, e.b});
          cont = !e.last;
        end
      end else begin
        low++;
      end
      if (bus.data_fifo_rd) begin
        run++;
      end else if (run != 0) begin
        if (rdq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_len: got run %0d want none cyc %0d", run, cyc);
        end else begin
          chk("rd_len", run, rdq.pop_front());
        end
        run = 0;
      end
      if (bus.ptr_fifo_rd) begin
        chk("pop_width", pprev, 0);
        if (!pprev) begin
          pops++;
          if (seen) chkmin("pop_gap", low, G);
        end
      end
      pprev = bus.ptr_fifo_rd;
      if (err) err_seen++;
    end
  end

  task automatic drain(int maxc);
    int i;
    bus.tx_rdy = 1'b1;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (dq.size() == 0 && exq.size() == 0 &&
          rdq.size() == 0 && !busy) break;
    end
    chk("drained", i < maxc, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sof(int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (bus.tx_sof) break;
    end
    chk("sof_seen", i < maxc, 1);
  endtask

  initial begin
    int p0;
    int t0;
    int i;
    int left;
    bus.tx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ptr_rd",  bus.ptr_fifo_rd, 0);
    chk("rst_data_rd", bus.data_fifo_rd, 0);
    chk("rst_sof",     bus.tx_sof, 0);
    chk("rst_dv",      bus.tx_dv, 0);
    chk("rst_data",    bus.tx_data, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_err",     err, 0);
    rstn = 1'b1;
    @(negedge clk);

    push_desc(62, 0, 1'b0);
    p0 = pops;
    repeat (20) @(negedge clk);
    chk("rdy0_no_pop", pops, p0);
    chk("rdy0_idle", busy, 0);
    bus.tx_rdy = 1'b1;
    @(negedge clk);
    chk("rdy1_pop", bus.ptr_fifo_rd, 1);
    wait_sof(20);
    repeat (10) @(negedge clk);
    bus.tx_rdy = 1'b0;
    repeat (30) @(negedge clk);
    drain(200);

    push_desc(0, $urandom_range(0, 255), 1'b0);
    drain(100);
    chk("n0_empty", bus.ptr_fifo_empty, 1);

    push_desc(100, $urandom_range(0, 255), 1'b0);
    push_desc(5, $urandom_range(0, 255), 1'b0);
    drain(400);

    push_desc(10, 0, 1'b1);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ptr_fifo_rd) break;
    end
    chk("tmo_pop", i < 50, 1);
    t0 = cyc;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) break;
    end
    chk("tmo_lat", cyc - t0, VT);
    drain(100);
    chk("tmo_idle", busy, 0);

    push_desc(200, $urandom_range(0, 255), 1'b0);
    wait_sof(50);
    repeat (12) @(posedge clk);
    #1;
    rstn = 1'b0;
    exq.delete();
    rdq.delete();
    #1;
    chk("arst_dv",      bus.tx_dv, 0);
    chk("arst_data",    bus.tx_data, 0);
    chk("arst_data_rd", bus.data_fifo_rd, 0);
    chk("arst_busy",    busy, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    push_desc(30, $urandom_range(0, 255), 1'b0);
    drain(200);

    push_desc(4094, $urandom_range(0, 255), 1'b0);
    push_desc(4095, $urandom_range(0, 255), 1'b0);
    drain(9000);

    left = 30;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      bus.tx_rdy = ($urandom_range(0, 3) != 0);
      if (left > 0 && dq.size() < 3 && $urandom_range(0, 15) == 0) begin
        push_desc(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                              : $urandom_range(4, 120),
                  $urandom_range(0, 255),
                  $urandom_range(0, 9) == 0);
        left--;
      end
      if (left == 0) break;
    end
    drain(3000);

    chk("err_count", err_seen, err_exp);
    chk("exp_left", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim still running at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
